os_decoder: RTL and testbench
=============================

# os_decoder

Receive-side counterpart of the transmit ordered-set generator in the PCIe PHY. The block accepts per-lane 8b/10b-decoded symbol beats on an AXI-Stream slave and reassembles TS1, TS2, EIOS and SKP ordered sets. For every lane it reports the type and contents of each decoded set, plus a count of consecutive identical training sets. It sits between the receive lane deskew and the LTSSM, and supports Gen1/Gen2 (8b/10b) only.

## Interface
- MAX_NUM_LANES, 4, lanes handled in parallel
- DATA_WIDTH, 32, per-lane beat width (4 symbols)
- KEEP_WIDTH, DATA_WIDTH/8, per-lane keep width
- USER_WIDTH, 4, per-lane K-flag width; bit b marks symbol b as a K symbol
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_WIDTH*MAX_NUM_LANES  lane i in bits [32i+:32], symbol 0 in the LSB byte
- s_axis_tkeep  in  KEEP_WIDTH*MAX_NUM_LANES  ignored; all ones expected
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of an ordered set
- s_axis_tuser  in  USER_WIDTH*MAX_NUM_LANES  K flags, lane i in [USER_WIDTH*i+:USER_WIDTH]
- s_axis_tready  out  1  held at 1 when out of reset
- clear_cnt_i  in  1  clears the consecutive counters and the stored previous sets
- os_valid_o  out  1  single-cycle pulse: a set has been decoded
- os_type_o  out  MAX_NUM_LANES x os_type_e  decoded type per lane
- os_data_o  out  MAX_NUM_LANES x pcie_tsos_t  the 16 received symbols per lane; word k in bits [32k+:32]
- ts_cnt_o  out  MAX_NUM_LANES x 8  consecutive identical TS count per lane, saturating at 255
- eios_o  out  1  pulse: EIOS decoded on lane 0
- err_o  out  1  pulse: a framing or symbol error was found on any lane

## Operation
**States**
- ST_IDLE: wait for a start beat. A start beat has lane 0 symbol 0 = COM_ (0xBC) with its K flag set.
  - If tlast is also set on the start beat, decode the set at once as a 1-beat set.
  - Otherwise set beat_cnt to 1 and move to ST_COLLECT.
  - A beat that is not a start beat is dropped.
- ST_COLLECT: store beat beat_cnt into os_data for all lanes.
  - tlast on beat 3: decode the set, then go to ST_IDLE.
  - tlast before beat 3: error, go to ST_IDLE.
  - No tlast on beat 3: error, go to ST_DISCARD.
- ST_DISCARD: drop beats until a beat with tlast arrives, then go to ST_IDLE.

**Decode rules (per lane)**
- TS1: symbol 0 is COM_ with K set; symbols 1–15 have K clear; symbols 10–15 all equal 0x4A.
- TS2: same as TS1, except symbols 10–15 all equal 0x45.
- PAD_ (K23.7, 0xF7, K set) is legal in symbol 1 (link number) and symbol 2 (lane number).
- EIOS: a 1-beat set of COM_ followed by three IDL_ (0x7C), all four symbols with K set.
- SKP: a 1-beat set of COM_ followed by three SKP_ (0x1C), all four symbols with K set.
- Anything else is OS_ERR. err_o pulses if any lane reports OS_ERR.

**Consecutive counter (per lane), evaluated when os_valid_o pulses**
- TS1/TS2 whose type and symbols 1–15 both equal the stored previous TS: count + 1, saturating at 255.
- Any other TS1/TS2: count = 1, and the stored previous TS is replaced.
- EIOS and SKP: counter and stored TS unchanged.
- OS_ERR: count = 0 and the stored TS is invalidated.
- clear_cnt_i has priority over everything else. A set decoded in the same cycle is discarded for counting: count = 0, stored TS invalid.

## Timing
- Reset values: all outputs 0; os_type_o = OS_NONE; state ST_IDLE; s_axis_tready = 0 while rst_ni is low, 1 from the first clock after rst_ni is released.
- A beat is accepted on any cycle with tvalid high. No backpressure is applied.
- Latency: os_valid_o, eios_o and err_o pulse exactly 1 cycle after the clock edge that accepted the tlast beat.
- os_type_o, os_data_o and ts_cnt_o are registered and hold their values until the next decode.
- Back-to-back sets with no idle cycles are decoded at full rate.
- Reset asserted mid-collect: the partial set is discarded and every output returns to its reset value.

## Structure
- Add to pcie_phy_pkg:
  - os_type_e {OS_NONE, OS_TS1, OS_TS2, OS_EIOS, OS_SKP, OS_ERR};
  - constants COM_, IDL_, SKP_, TS1_ID (0x4A), TS2_ID (0x45). PAD_ already exists in the package.
- One sub-module, os_lane_decode: a per-lane classifier plus the consecutive counter, instantiated MAX_NUM_LANES times.
- The FSM, beat counter and pulse outputs stay in the top level.

## Test plan
- Reset: drive beats while rst_ni = 0 -> tready = 0, all outputs 0, os_type_o = OS_NONE.
- 8 identical TS1 back to back, link 0, lanes 0–3 -> 8 os_valid_o pulses; ts_cnt_o on every lane goes 1..8; os_type_o = OS_TS1; os_data_o lane i symbol 2 = i.
- 4 TS1 followed by 1 TS2 -> ts_cnt_o = 4, then 1 with OS_TS2. Insert a SKP between the 4th TS1 and the TS2 -> counter unchanged by the SKP, os_type_o = OS_SKP on that pulse.
- EIOS beat (BC 7C 7C 7C, K = 0xF per lane, tlast) -> eios_o pulses 1 cycle after the beat; counters unchanged.
- tlast on beat 2 of a TS -> err_o pulse, OS_ERR, counters 0. A following valid TS1 -> ts_cnt_o = 1.
- clear_cnt_i asserted in the decode cycle of the 5th identical TS1 -> ts_cnt_o = 0. The next identical TS1 -> ts_cnt_o = 1.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY types and symbol constants for the ordered-set datapath.
package pcie_phy_pkg;

  // 8b/10b control and data symbols used by ordered sets
  localparam logic [7:0] COM_   = 8'hBC;  // K28.5 comma
  localparam logic [7:0] PAD_   = 8'hF7;  // K23.7 pad
  localparam logic [7:0] IDL_   = 8'h7C;  // K28.3 electrical idle
  localparam logic [7:0] SKP_   = 8'h1C;  // K28.0 skip
  localparam logic [7:0] TS1_ID = 8'h4A;  // D10.2 TS1 identifier
  localparam logic [7:0] TS2_ID = 8'h45;  // D5.2 TS2 identifier

  // A training set is 16 symbols
  localparam int OS_SYMS = 16;

  typedef logic [8*OS_SYMS-1:0] pcie_tsos_t;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_EIOS = 3'd3,
    OS_SKP  = 3'd4,
    OS_ERR  = 3'd5
  } os_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } os_rx_state_e;

  // Extract symbol s from a 16-symbol set (symbol 0 in the LSB byte)
  function automatic logic [7:0] os_sym(input pcie_tsos_t d, input int s);
    return d[8*s +: 8];
  endfunction

endpackage

// File: rtl/os_lane_decode.sv
// Per-lane ordered-set classifier and consecutive identical TS counter.
module os_lane_decode
  import pcie_phy_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dec_en_i,
  input  logic                 one_beat_i,
  input  logic                 force_err_i,
  input  logic                 clear_i,
  input  pcie_tsos_t           sym_i,
  input  logic [OS_SYMS-1:0]   k_i,
  output os_type_e             cls_o,
  output os_type_e             type_o,
  output pcie_tsos_t           data_o,
  output logic [7:0]           cnt_o
);

  logic ts_frame;
  logic all_ts1;
  logic all_ts2;
  logic eios_hit;
  logic skp_hit;
  logic same_ts;

  os_type_e                type_reg;
  pcie_tsos_t              data_reg;
  logic [7:0]              cnt_reg;
  logic [8*OS_SYMS-9:0]    prev_sym_reg;
  os_type_e                prev_type_reg;
  logic                    prev_valid_reg;

  // Classify the buffered set from its symbols and K flags
  always_comb begin
    ts_frame = (os_sym(sym_i, 0) == COM_) && k_i[0];
    for (int s = 1; s < OS_SYMS; s++) begin
      // only the link and lane number slots may carry a K symbol, and only PAD
      if (k_i[s] && !((s == 1 || s == 2) && os_sym(sym_i, s) == PAD_)) begin
        ts_frame = 1'b0;
      end
    end
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int s = 10; s < OS_SYMS; s++) begin
      if (os_sym(sym_i, s) != TS1_ID) all_ts1 = 1'b0;
      if (os_sym(sym_i, s) != TS2_ID) all_ts2 = 1'b0;
    end
    eios_hit = (k_i[3:0] == 4'hF) && (sym_i[7:0] == COM_) &&
               (sym_i[15:8] == IDL_) && (sym_i[23:16] == IDL_) && (sym_i[31:24] == IDL_);
    skp_hit  = (k_i[3:0] == 4'hF) && (sym_i[7:0] == COM_) &&
               (sym_i[15:8] == SKP_) && (sym_i[23:16] == SKP_) && (sym_i[31:24] == SKP_);
    cls_o = OS_ERR;
    if (force_err_i) begin
      cls_o = OS_ERR;
    end else if (one_beat_i) begin
      if (eios_hit)     cls_o = OS_EIOS;
      else if (skp_hit) cls_o = OS_SKP;
    end else if (ts_frame && all_ts1) begin
      cls_o = OS_TS1;
    end else if (ts_frame && all_ts2) begin
      cls_o = OS_TS2;
    end
  end

  // Identity excludes the COM symbol, which is common to every TS
  assign same_ts = prev_valid_reg && (cls_o == prev_type_reg) &&
                   (sym_i[8*OS_SYMS-1:8] == prev_sym_reg);

  // Register the decoded set and track runs of identical training sets
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_reg       <= OS_NONE;
      data_reg       <= '0;
      cnt_reg        <= 8'd0;
      prev_sym_reg   <= '0;
      prev_type_reg  <= OS_NONE;
      prev_valid_reg <= 1'b0;
    end else begin
      if (dec_en_i) begin
        type_reg <= cls_o;
        data_reg <= sym_i;
      end
      if (clear_i) begin
        cnt_reg        <= 8'd0;
        prev_valid_reg <= 1'b0;
      end else if (dec_en_i) begin
        case (cls_o)
          OS_TS1, OS_TS2: begin
            if (same_ts) begin
              if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
            end else begin
              cnt_reg        <= 8'd1;
              prev_sym_reg   <= sym_i[8*OS_SYMS-1:8];
              prev_type_reg  <= cls_o;
              prev_valid_reg <= 1'b1;
            end
          end
          OS_ERR: begin
            cnt_reg        <= 8'd0;
            prev_valid_reg <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign type_o = type_reg;
  assign data_o = data_reg;
  assign cnt_o  = cnt_reg;

endmodule

// File: rtl/os_decoder.sv
// Receive ordered-set decoder: frames symbol beats into sets and decodes every lane.
module os_decoder
  import pcie_phy_pkg::*;
#(
  parameter int MAX_NUM_LANES = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [DATA_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  input  logic [USER_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tuser,
  output logic                                  s_axis_tready,
  input  logic                                  clear_cnt_i,
  output logic                                  os_valid_o,
  output os_type_e   [MAX_NUM_LANES-1:0]        os_type_o,
  output pcie_tsos_t [MAX_NUM_LANES-1:0]        os_data_o,
  output logic [MAX_NUM_LANES-1:0][7:0]         ts_cnt_o,
  output logic                                  eios_o,
  output logic                                  err_o
);

  os_rx_state_e                          state_reg;
  logic [1:0]                            beat_cnt_reg;
  pcie_tsos_t [MAX_NUM_LANES-1:0]        buf_data_reg;
  logic [MAX_NUM_LANES-1:0][OS_SYMS-1:0] buf_k_reg;
  logic                                  dec_pend_reg;
  logic                                  one_beat_reg;
  logic                                  force_err_reg;
  logic                                  tready_reg;
  logic                                  os_valid_reg;
  logic                                  eios_reg;
  logic                                  err_reg;

  os_type_e [MAX_NUM_LANES-1:0]          lane_cls;
  logic     [MAX_NUM_LANES-1:0]          lane_err;
  logic                                  start_beat;
  logic                                  unused_keep;

  // Keep is all ones on this link; it carries no information
  assign unused_keep = ^s_axis_tkeep;

  assign start_beat = s_axis_tvalid && (s_axis_tdata[7:0] == COM_) && s_axis_tuser[0];

  // Framing FSM: collect beats into the set buffer and schedule one decode per set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= 2'd0;
      buf_data_reg  <= '0;
      buf_k_reg     <= '0;
      dec_pend_reg  <= 1'b0;
      one_beat_reg  <= 1'b0;
      force_err_reg <= 1'b0;
      tready_reg    <= 1'b0;
      os_valid_reg  <= 1'b0;
      eios_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      tready_reg   <= 1'b1;
      dec_pend_reg <= 1'b0;
      // pulses report the set captured on the previous edge
      os_valid_reg <= dec_pend_reg;
      eios_reg     <= dec_pend_reg && (lane_cls[0] == OS_EIOS);
      err_reg      <= dec_pend_reg && (|lane_err);
      case (state_reg)
        ST_IDLE: begin
          if (start_beat) begin
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
              // stale symbols of an earlier set must not leak into a short set
              buf_data_reg[l] <= pcie_tsos_t'(s_axis_tdata[DATA_WIDTH*l +: DATA_WIDTH]);
              buf_k_reg[l]    <= (OS_SYMS)'(s_axis_tuser[USER_WIDTH*l +: USER_WIDTH]);
            end
            if (s_axis_tlast) begin
              dec_pend_reg  <= 1'b1;
              one_beat_reg  <= 1'b1;
              force_err_reg <= 1'b0;
            end else begin
              beat_cnt_reg <= 2'd1;
              state_reg    <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (s_axis_tvalid) begin
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
              buf_data_reg[l][DATA_WIDTH*beat_cnt_reg +: DATA_WIDTH] <=
                s_axis_tdata[DATA_WIDTH*l +: DATA_WIDTH];
              buf_k_reg[l][USER_WIDTH*beat_cnt_reg +: USER_WIDTH] <=
                s_axis_tuser[USER_WIDTH*l +: USER_WIDTH];
            end
            if (beat_cnt_reg == 2'd3) begin
              dec_pend_reg  <= 1'b1;
              one_beat_reg  <= 1'b0;
              force_err_reg <= !s_axis_tlast;
              state_reg     <= s_axis_tlast ? ST_IDLE : ST_DISCARD;
            end else if (s_axis_tlast) begin
              dec_pend_reg  <= 1'b1;
              one_beat_reg  <= 1'b0;
              force_err_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
          end
        end
        ST_DISCARD: begin
          if (s_axis_tvalid && s_axis_tlast) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_NUM_LANES; gi++) begin : g_lane
      os_lane_decode u_lane (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dec_en_i    (dec_pend_reg),
        .one_beat_i  (one_beat_reg),
        .force_err_i (force_err_reg),
        .clear_i     (clear_cnt_i),
        .sym_i       (buf_data_reg[gi]),
        .k_i         (buf_k_reg[gi]),
        .cls_o       (lane_cls[gi]),
        .type_o      (os_type_o[gi]),
        .data_o      (os_data_o[gi]),
        .cnt_o       (ts_cnt_o[gi])
      );
      assign lane_err[gi] = (lane_cls[gi] == OS_ERR);
    end
  endgenerate

  assign s_axis_tready = tready_reg;
  assign os_valid_o    = os_valid_reg;
  assign eios_o        = eios_reg;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_os_decoder.sv
// Directed testbench for os_decoder with a set-level reference model and per-cycle compare.
module tb_os_decoder;
  import pcie_phy_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [127:0]        s_axis_tdata = '0;
  logic [15:0]         s_axis_tkeep = '1;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast = 1'b0;
  logic [15:0]         s_axis_tuser = '0;
  logic                s_axis_tready;
  logic                clear_cnt_i = 1'b0;
  logic                os_valid_o;
  os_type_e   [3:0]    os_type_o;
  pcie_tsos_t [3:0]    os_data_o;
  logic [3:0][7:0]     ts_cnt_o;
  logic                eios_o;
  logic                err_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit clr_next = 1'b0;

  typedef struct {
    int                due;
    os_type_e [3:0]    typ;
    logic [3:0][127:0] data;
    logic [127:0]      dmask;
    logic [3:0][7:0]   cnt;
    bit                eios;
    bit                err;
  } exp_t;

  exp_t q[$];

  // reference model state per lane
  logic [7:0]   mcnt[4];
  bit           mpv[4];
  os_type_e     mpt[4];
  logic [119:0] mprev[4];

  logic [3:0][127:0] sd;
  logic [3:0][15:0]  sk;

  os_decoder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .clear_cnt_i   (clear_cnt_i),
    .os_valid_o    (os_valid_o),
    .os_type_o     (os_type_o),
    .os_data_o     (os_data_o),
    .ts_cnt_o      (ts_cnt_o),
    .eios_o        (eios_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 8'd0; mpv[i] = 1'b0; mpt[i] = OS_NONE; mprev[i] = '0;
    end
  endtask

  // Set-level classification straight from the ordered-set rules
  function automatic os_type_e model_class(input logic [127:0] d, input logic [15:0] k,
                                           input bit one, input bit frame_ok);
    logic [7:0] s[16];
    int n1, n2;
    if (!frame_ok) return OS_ERR;
    for (int j = 0; j < 16; j++) s[j] = d[8*j +: 8];
    if (one) begin
      if (k[3:0] != 4'hF || s[0] != 8'hBC) return OS_ERR;
      if (s[1] == 8'h7C && s[2] == 8'h7C && s[3] == 8'h7C) return OS_EIOS;
      if (s[1] == 8'h1C && s[2] == 8'h1C && s[3] == 8'h1C) return OS_SKP;
      return OS_ERR;
    end
    if (s[0] != 8'hBC || !k[0]) return OS_ERR;
    for (int j = 1; j < 16; j++)
      if (k[j] && !(j <= 2 && s[j] == 8'hF7)) return OS_ERR;
    n1 = 0; n2 = 0;
    for (int j = 10; j < 16; j++) begin
      if (s[j] == 8'h4A) n1++;
      if (s[j] == 8'h45) n2++;
    end
    if (n1 == 6) return OS_TS1;
    if (n2 == 6) return OS_TS2;
    return OS_ERR;
  endfunction

  task automatic model_push(input logic [3:0][127:0] d, input logic [3:0][15:0] k,
                            input bit one, input bit ok, input bit clr);
    exp_t e;
    os_type_e t;
    e.due = cyc + 1;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = model_class(d[i], k[i], one, ok);
      e.typ[i] = t;
      if (t == OS_ERR) e.err = 1'b1;
      if (clr) begin
        mcnt[i] = 8'd0; mpv[i] = 1'b0;
      end else if (t == OS_TS1 || t == OS_TS2) begin
        if (mpv[i] && mpt[i] == t && mprev[i] == d[i][127:8]) begin
          if (mcnt[i] != 8'd255) mcnt[i] = mcnt[i] + 8'd1;
        end else begin
          mcnt[i] = 8'd1; mpv[i] = 1'b1; mpt[i] = t; mprev[i] = d[i][127:8];
        end
      end else if (t == OS_ERR) begin
        mcnt[i] = 8'd0; mpv[i] = 1'b0;
      end
      e.cnt[i] = mcnt[i];
    end
    e.data  = d;
    e.dmask = !ok ? 128'h0 : (one ? 128'hFFFF_FFFF : '1);
    e.eios  = (e.typ[0] == OS_EIOS);
    q.push_back(e);
    if (clr) clr_next = 1'b1;
  endtask

  task automatic drive_beat(input logic [127:0] data, input logic [15:0] user,
                            input bit v, input bit last);
    clear_cnt_i   = clr_next;
    clr_next      = 1'b0;
    s_axis_tdata  = data;
    s_axis_tuser  = user;
    s_axis_tvalid = v;
    s_axis_tlast  = last;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive_beat('0, '0, 1'b0, 1'b0);
  endtask

  // Send one set of nbeats beats; tlast on beat last_idx (-1: never)
  task automatic send_set(input logic [3:0][127:0] d, input logic [3:0][15:0] k,
                          input int nbeats, input int last_idx, input bit clr);
    int ev, w;
    bit one, ok;
    logic [127:0] td;
    logic [15:0] tu;
    one = (nbeats == 1);
    ev  = one ? 0 : ((last_idx >= 0 && last_idx < 3) ? last_idx : 3);
    ok  = one ? (last_idx == 0) : (last_idx == 3);
    for (int b = 0; b < nbeats; b++) begin
      w = b % 4;
      for (int i = 0; i < 4; i++) begin
        td[32*i +: 32] = d[i][32*w +: 32];
        tu[4*i +: 4]   = k[i][4*w +: 4];
      end
      drive_beat(td, tu, 1'b1, b == last_idx);
      if (b == ev) model_push(d, k, one, ok, clr);
    end
  endtask

  function automatic logic [127:0] mk_ts(input logic [7:0] link, input logic [7:0] lane,
                                         input logic [7:0] id);
    logic [127:0] d;
    d[7:0] = 8'hBC; d[15:8] = link; d[23:16] = lane;
    d[31:24] = 8'h10; d[39:32] = 8'h02; d[47:40] = 8'h00;
    for (int j = 6; j < 16; j++) d[8*j +: 8] = id;
    return d;
  endfunction

  task automatic build_ts(input logic [7:0] link, input bit pad_link, input logic [7:0] id);
    for (int i = 0; i < 4; i++) begin
      sd[i] = mk_ts(link, 8'(i), id);
      sk[i] = pad_link ? 16'h0003 : 16'h0001;
    end
  endtask

  task automatic build_short(input logic [7:0] sym);
    for (int i = 0; i < 4; i++) begin
      sd[i] = {96'h0, sym, sym, sym, 8'hBC};
      sk[i] = 16'h000F;
    end
  endtask

  task automatic check_lanes(input string tag, input logic [7:0] cnt, input os_type_e t);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_cnt_lane%0d", tag, i), ts_cnt_o[i], cnt);
      check($sformatf("%s_type_lane%0d", tag, i), os_type_o[i], t);
    end
  endtask

  // Compare DUT outputs against the model queue on every cycle out of reset
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (q.size() > 0 && q[0].due < cyc) begin
          check("decode_overdue", 128'(q[0].due), 128'(cyc));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          check("os_valid_pulse", os_valid_o, 1'b1);
          check("eios_pulse", eios_o, e.eios);
          check("err_pulse", err_o, e.err);
          for (int i = 0; i < 4; i++) begin
            check($sformatf("type_lane%0d", i), os_type_o[i], e.typ[i]);
            check($sformatf("cnt_lane%0d", i), ts_cnt_o[i], e.cnt[i]);
            if (e.dmask != '0)
              check($sformatf("data_lane%0d", i), os_data_o[i] & e.dmask, e.data[i] & e.dmask);
          end
        end else begin
          check("pulses_quiet", {os_valid_o, eios_o, err_o}, 3'b000);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    reset_model();

    // beats during reset are ignored and outputs sit at reset values
    build_ts(8'h00, 1'b0, 8'h4A);
    for (int b = 0; b < 4; b++) drive_beat({sd[3][32*b +: 32], sd[2][32*b +: 32],
                                            sd[1][32*b +: 32], sd[0][32*b +: 32]},
                                           16'h1111, 1'b1, b == 3);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_pulses", {os_valid_o, eios_o, err_o}, 3'b000);
    for (int i = 0; i < 4; i++) check($sformatf("rst_data_lane%0d", i), os_data_o[i], 128'h0);
    check_lanes("rst", 8'd0, OS_NONE);
    rst_ni = 1'b1;
    idle(1);
    check("tready_up", s_axis_tready, 1'b1);

    // 8 identical TS1 back to back
    build_ts(8'h00, 1'b0, 8'h4A);
    for (int n = 0; n < 8; n++) send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("ts1x8", 8'd8, OS_TS1);
    for (int i = 0; i < 4; i++)
      check($sformatf("lane_num%0d", i), os_data_o[i][23:16], 8'(i));

    // 4 TS1 with PAD link, a SKP, then a TS2
    build_ts(8'hF7, 1'b1, 8'h4A);
    for (int n = 0; n < 4; n++) send_set(sd, sk, 4, 3, 1'b0);
    build_short(8'h1C);
    send_set(sd, sk, 1, 0, 1'b0);
    idle(2);
    check_lanes("skp", 8'd4, OS_SKP);
    build_ts(8'hF7, 1'b1, 8'h45);
    send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("ts2", 8'd1, OS_TS2);

    // EIOS: pulse exactly one cycle after the accepting edge
    build_short(8'h7C);
    send_set(sd, sk, 1, 0, 1'b0);
    check("eios_early", eios_o, 1'b0);
    idle(1);
    check("eios_on_time", eios_o, 1'b1);
    idle(1);
    check("eios_gone", eios_o, 1'b0);
    check_lanes("eios", 8'd1, OS_EIOS);

    // tlast on beat 2 is a framing error
    build_ts(8'h00, 1'b0, 8'h4A);
    send_set(sd, sk, 3, 2, 1'b0);
    idle(1);
    check("short_err", err_o, 1'b1);
    idle(1);
    check_lanes("short", 8'd0, OS_ERR);
    send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("recover", 8'd1, OS_TS1);

    // missing tlast on beat 3: error, then discard up to the tlast beat
    send_set(sd, sk, 5, 4, 1'b0);
    idle(2);
    check_lanes("long", 8'd0, OS_ERR);
    send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("after_discard", 8'd1, OS_TS1);

    // clear in the decode cycle of the 5th identical TS1
    for (int n = 0; n < 4; n++) send_set(sd, sk, 4, 3, n == 3);
    idle(2);
    check_lanes("cleared", 8'd0, OS_TS1);
    send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("post_clear", 8'd1, OS_TS1);

    // reset in the middle of a set
    send_set(sd, sk, 2, -1, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("midrst_tready", s_axis_tready, 1'b0);
    check_lanes("midrst", 8'd0, OS_NONE);
    idle(2);
    rst_ni = 1'b1;
    reset_model();
    idle(1);
    send_set(sd, sk, 4, 3, 1'b0);
    idle(2);
    check_lanes("post_rst", 8'd1, OS_TS1);

    // saturation at 255
    for (int n = 0; n < 255; n++) send_set(sd, sk, 4, 3, 1'b0);
    idle(3);
    check_lanes("sat", 8'd255, OS_TS1);

    idle(3);
    check("queue_drained", 128'(q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
